regfile_wb_arbiter: RTL

//  Shares the two register-file write ports (wen0/waddr0/wdata0, wen1/waddr1/wdata1) among NUM_REQ

---
 rtl/regfile_wb_arbiter_pkg.sv | 17 +
 rtl/regfile_wb_arbiter_rr_pick.sv | 32 +++
 rtl/regfile_wb_arbiter.sv | 121 ++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter_pkg
// Purpose : Shared widths for the writeback arbiter and the register file it
//           feeds. This package stands in for the shared define.vh values.
// Contents: REG_ADDRW  - register address width
//           WORD_SIZE  - register data width
//           REG_DEPTH  - number of architectural registers
//           WB_NUM_REQ - default number of writeback requesters
// -----------------------------------------------------------------------------
package regfile_wb_arbiter_pkg;

  localparam int REG_ADDRW  = 5;
  localparam int WORD_SIZE  = 32;
  localparam int REG_DEPTH  = 32;
  localparam int WB_NUM_REQ = 4;

endpackage

// File: rtl/regfile_wb_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Purpose : Combinational round-robin picker. Returns the first set bit of the
//           mask at or after the pointer, wrapping from NUM_REQ-1 back to 0.
// Ports   : i_mask  [NUM_REQ] candidate bits
//           i_ptr   [PTR_W]   scan start position
//           o_found           at least one mask bit is set
//           o_idx   [PTR_W]   index of the chosen bit (0 when nothing found)
// -----------------------------------------------------------------------------
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] i_mask,
  input  logic [PTR_W-1:0]   i_ptr,
  output logic               o_found,
  output logic [PTR_W-1:0]   o_idx
);

  // Walk the scan order backwards so the candidate nearest the pointer is
  // the last one written and therefore wins.
  always_comb begin
    o_found = |i_mask;
    o_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (i_mask[(int'(i_ptr) + k) % NUM_REQ]) begin
        o_idx = PTR_W'((int'(i_ptr) + k) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
// Purpose : Shares the two register-file write ports among NUM_REQ writeback
//           requesters. Up to two requesters are granted per cycle in
//           round-robin order, never two with the same register address.
//           Granted writes are registered and driven to the register file on
//           the following cycle.
// Ports   : clk, rst              clock / async active-high reset
//           wb_stall              1 = grant nothing this cycle
//           req_valid [NUM_REQ]   per-requester write request
//           req_addr, req_data    flattened per-requester address / data
//           req_ready [NUM_REQ]   combinational grant (transfer = valid&ready)
//           wen0/waddr0/wdata0    registered write port 0 (slot 0)
//           wen1/waddr1/wdata1    registered write port 1 (slot 1)
// -----------------------------------------------------------------------------
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int NUM_REQ = WB_NUM_REQ,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wb_stall,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*REG_ADDRW-1:0]   req_addr,
  input  logic [NUM_REQ*WORD_SIZE-1:0]   req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           wen0,
  output logic                           wen1,
  output logic [REG_ADDRW-1:0]           waddr0,
  output logic [REG_ADDRW-1:0]           waddr1,
  output logic [WORD_SIZE-1:0]           wdata0,
  output logic [WORD_SIZE-1:0]           wdata1
);

  logic [PTR_W-1:0]     r_rrPtr;
  logic                 w_found0;
  logic                 w_found1;
  logic [PTR_W-1:0]     w_idx0;
  logic [PTR_W-1:0]     w_idx1;
  logic [NUM_REQ-1:0]   w_oneHot0;
  logic [NUM_REQ-1:0]   w_oneHot1;
  logic [NUM_REQ-1:0]   w_addrMatch;
  logic [NUM_REQ-1:0]   w_mask1;
  logic [REG_ADDRW-1:0] w_slot0Addr;
  logic [REG_ADDRW-1:0] w_slot1Addr;
  logic [WORD_SIZE-1:0] w_slot0Data;
  logic [WORD_SIZE-1:0] w_slot1Data;
  logic                 w_grant0;
  logic                 w_grant1;
  logic [PTR_W-1:0]     w_lastIdx;
  logic [PTR_W-1:0]     w_nextPtr;

  rr_pick #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_pick0 (
    .i_mask  (req_valid),
    .i_ptr   (r_rrPtr),
    .o_found (w_found0),
    .o_idx   (w_idx0)
  );

  // Slot 1 excludes the slot 0 winner and everyone targeting its address;
  // those collided requesters simply retry next cycle.
  always_comb begin
    w_slot0Addr = req_addr[w_idx0*REG_ADDRW +: REG_ADDRW];
    w_slot0Data = req_data[w_idx0*WORD_SIZE +: WORD_SIZE];
    w_oneHot0   = NUM_REQ'(1) << w_idx0;
    w_addrMatch = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_addrMatch[i] = (req_addr[i*REG_ADDRW +: REG_ADDRW] == w_slot0Addr);
    end
    w_mask1 = req_valid & ~w_oneHot0 & ~w_addrMatch;
  end

  rr_pick #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_pick1 (
    .i_mask  (w_mask1),
    .i_ptr   (r_rrPtr),
    .o_found (w_found1),
    .o_idx   (w_idx1)
  );

  // Grants are suppressed while stalled and while reset is high, so a
  // handshake can never be observed for a write that reset will discard.
  always_comb begin
    w_slot1Addr = req_addr[w_idx1*REG_ADDRW +: REG_ADDRW];
    w_slot1Data = req_data[w_idx1*WORD_SIZE +: WORD_SIZE];
    w_oneHot1   = NUM_REQ'(1) << w_idx1;
    w_grant0    = w_found0 & ~wb_stall & ~rst;
    w_grant1    = w_found1 & ~wb_stall & ~rst;
    req_ready   = (w_grant0 ? w_oneHot0 : '0) | (w_grant1 ? w_oneHot1 : '0);
    w_lastIdx   = w_grant1 ? w_idx1 : w_idx0;
    w_nextPtr   = (int'(w_lastIdx) == NUM_REQ - 1) ? '0 : w_lastIdx + 1'b1;
  end

  // Write-port registers and the round-robin pointer. An empty slot drops
  // its enable but keeps its last address/data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wen0    <= 1'b0;
      wen1    <= 1'b0;
      waddr0  <= '0;
      waddr1  <= '0;
      wdata0  <= '0;
      wdata1  <= '0;
      r_rrPtr <= '0;
    end else begin
      wen0 <= w_grant0;
      wen1 <= w_grant1;
      if (w_grant0) begin
        waddr0  <= w_slot0Addr;
        wdata0  <= w_slot0Data;
        r_rrPtr <= w_nextPtr;
      end
      if (w_grant1) begin
        waddr1 <= w_slot1Addr;
        wdata1 <= w_slot1Data;
      end
    end
  end

endmodule
